// File: rtl/decode_out_pkg_hdl.sv
// LC-3 decode-stage encodings shared by the decode RTL, the decode_out agent and the predictor.
// E_control is {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
package decode_out_pkg_hdl;

    typedef enum logic [3:0] {
        OpBr    = 4'h0,
        OpAdd   = 4'h1,
        OpLd    = 4'h2,
        OpSt    = 4'h3,
        OpRes4  = 4'h4,
        OpAnd   = 4'h5,
        OpLdr   = 4'h6,
        OpStr   = 4'h7,
        OpRti   = 4'h8,
        OpNot   = 4'h9,
        OpLdi   = 4'hA,
        OpSti   = 4'hB,
        OpJmp   = 4'hC,
        OpRes13 = 4'hD,
        OpLea   = 4'hE,
        OpTrap  = 4'hF
    } opcode_e;

    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] AluAnd = 2'b01;
    localparam logic [1:0] AluNot = 2'b10;

    localparam logic [1:0] Pc1None = 2'b00;
    localparam logic [1:0] Pc1Off9 = 2'b01;
    localparam logic [1:0] Pc1Off6 = 2'b10;
    localparam logic [1:0] Pc1Zero = 2'b11;

    localparam logic Pc2Npc  = 1'b1;
    localparam logic Pc2Vsr1 = 1'b0;
    localparam logic Op2Vsr2 = 1'b1;
    localparam logic Op2Imm5 = 1'b0;

    localparam logic [1:0] WbAlu = 2'b00;
    localparam logic [1:0] WbMem = 2'b01;
    localparam logic [1:0] WbPc  = 2'b10;

    localparam int unsigned ECtrlW  = 6;
    localparam int unsigned EAluLsb = 4;
    localparam int unsigned EPc1Lsb = 2;
    localparam int unsigned EPc2Bit = 1;
    localparam int unsigned EOp2Bit = 0;

    function automatic logic [ECtrlW-1:0] pack_e(input logic [1:0] alu, input logic [1:0] pc1,
                                                 input logic pc2, input logic op2);
        logic [ECtrlW-1:0] e;
        e = '0;
        e[EAluLsb +: 2] = alu;
        e[EPc1Lsb +: 2] = pc1;
        e[EPc2Bit]      = pc2;
        e[EOp2Bit]      = op2;
        return e;
    endfunction

endpackage

// File: rtl/lc3_decode_ctrl.sv
// Combinational opcode decoder: opcode and immediate-mode bit to execute/writeback/memory controls.
module lc3_decode_ctrl
    import decode_out_pkg_hdl::*;
(
    input  logic [3:0]        opcode_i,
    input  logic              imm_bit_i,
    output logic [ECtrlW-1:0] e_control_o,
    output logic [1:0]        w_control_o,
    output logic              mem_control_o,
    output logic              illegal_op_o
);

    always_comb begin
        e_control_o   = pack_e(AluAdd, Pc1None, Pc2Vsr1, Op2Imm5);
        w_control_o   = WbAlu;
        mem_control_o = 1'b0;
        illegal_op_o  = 1'b0;
        unique case (opcode_e'(opcode_i))
            OpAdd: e_control_o = pack_e(AluAdd, Pc1None, Pc2Vsr1,
                                        imm_bit_i ? Op2Imm5 : Op2Vsr2);
            OpAnd: e_control_o = pack_e(AluAnd, Pc1None, Pc2Vsr1,
                                        imm_bit_i ? Op2Imm5 : Op2Vsr2);
            OpNot: e_control_o = pack_e(AluNot, Pc1None, Pc2Vsr1, Op2Imm5);
            OpBr, OpSt: e_control_o = pack_e(AluAdd, Pc1Off9, Pc2Npc, Op2Imm5);
            OpLd: begin
                e_control_o = pack_e(AluAdd, Pc1Off9, Pc2Npc, Op2Imm5);
                w_control_o = WbMem;
            end
            OpLdi: begin
                e_control_o   = pack_e(AluAdd, Pc1Off9, Pc2Npc, Op2Imm5);
                w_control_o   = WbMem;
                mem_control_o = 1'b1;
            end
            OpSti: begin
                e_control_o   = pack_e(AluAdd, Pc1Off9, Pc2Npc, Op2Imm5);
                mem_control_o = 1'b1;
            end
            OpLea: begin
                e_control_o = pack_e(AluAdd, Pc1Off9, Pc2Npc, Op2Imm5);
                w_control_o = WbPc;
            end
            OpLdr: begin
                e_control_o = pack_e(AluAdd, Pc1Off6, Pc2Vsr1, Op2Imm5);
                w_control_o = WbMem;
            end
            OpStr: e_control_o = pack_e(AluAdd, Pc1Off6, Pc2Vsr1, Op2Imm5);
            OpJmp: e_control_o = pack_e(AluAdd, Pc1Zero, Pc2Vsr1, Op2Imm5);
            OpRes4, OpRti, OpRes13, OpTrap: illegal_op_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/lc3_decode.sv
// LC-3 decode stage: captures instruction, next-PC and decoded controls when enable_decode is high.
module lc3_decode
    import decode_out_pkg_hdl::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_decode,
    input  logic [15:0] instr_dout,
    input  logic [15:0] npc_in,
    output logic [15:0] IR,
    output logic [15:0] npc_out,
    output logic [5:0]  E_control,
    output logic [1:0]  W_control,
    output logic        Mem_control,
    output logic        illegal_op
);

    logic [ECtrlW-1:0] dec_e;
    logic [1:0]        dec_w;
    logic              dec_mem;
    logic              dec_ill;

    logic [15:0]       ir_q, ir_d;
    logic [15:0]       npc_q, npc_d;
    logic [ECtrlW-1:0] e_q, e_d;
    logic [1:0]        w_q, w_d;
    logic              mem_q, mem_d;
    logic              ill_q, ill_d;

    lc3_decode_ctrl u_ctrl (
        .opcode_i      (instr_dout[15:12]),
        .imm_bit_i     (instr_dout[5]),
        .e_control_o   (dec_e),
        .w_control_o   (dec_w),
        .mem_control_o (dec_mem),
        .illegal_op_o  (dec_ill)
    );

    always_comb begin
        ir_d  = ir_q;
        npc_d = npc_q;
        e_d   = e_q;
        w_d   = w_q;
        mem_d = mem_q;
        ill_d = ill_q;
        if (enable_decode) begin
            ir_d  = instr_dout;
            npc_d = npc_in;
            e_d   = dec_e;
            w_d   = dec_w;
            mem_d = dec_mem;
            ill_d = dec_ill;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir_q  <= '0;
            npc_q <= '0;
            e_q   <= '0;
            w_q   <= '0;
            mem_q <= 1'b0;
            ill_q <= 1'b0;
        end else begin
            ir_q  <= ir_d;
            npc_q <= npc_d;
            e_q   <= e_d;
            w_q   <= w_d;
            mem_q <= mem_d;
            ill_q <= ill_d;
        end
    end

    assign IR          = ir_q;
    assign npc_out     = npc_q;
    assign E_control   = e_q;
    assign W_control   = w_q;
    assign Mem_control = mem_q;
    assign illegal_op  = ill_q;

endmodule

// File: tb/tb_lc3_decode.sv
// Scoreboard bench for lc3_decode: expected vectors are queued at drive time and popped after the edge.
module tb_lc3_decode;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_decode;
    logic [15:0] instr_dout;
    logic [15:0] npc_in;
    logic [15:0] IR;
    logic [15:0] npc_out;
    logic [5:0]  E_control;
    logic [1:0]  W_control;
    logic        Mem_control;
    logic        illegal_op;

    int errors = 0;
    int checks = 0;
    logic [41:0] sb_q[$];
    logic [41:0] exp_v;

    lc3_decode dut (
        .clock         (clock),
        .reset         (reset),
        .enable_decode (enable_decode),
        .instr_dout    (instr_dout),
        .npc_in        (npc_in),
        .IR            (IR),
        .npc_out       (npc_out),
        .E_control     (E_control),
        .W_control     (W_control),
        .Mem_control   (Mem_control),
        .illegal_op    (illegal_op)
    );

    always #5 clock = ~clock;

    // {IR, npc_out, E_control, W_control, Mem_control, illegal_op}
    function automatic logic [41:0] observed();
        return {IR, npc_out, E_control, W_control, Mem_control, illegal_op};
    endfunction

    function automatic logic [41:0] vec(input logic [15:0] ir, input logic [15:0] npc,
                                        input logic [5:0] e, input logic [1:0] w,
                                        input logic m, input logic il);
        return {ir, npc, e, w, m, il};
    endfunction

    function automatic logic [41:0] model(input logic [15:0] ins, input logic [15:0] npc);
        logic [5:0] e;
        logic [1:0] w;
        logic       m;
        logic       il;
        e = 6'b0; w = 2'b0; m = 1'b0; il = 1'b0;
        case (ins[15:12])
            4'h1: e = ins[5] ? 6'b000000 : 6'b000001;
            4'h5: e = ins[5] ? 6'b010000 : 6'b010001;
            4'h9: e = 6'b100000;
            4'h0, 4'h3: e = 6'b000110;
            4'h2: begin e = 6'b000110; w = 2'b01; end
            4'hA: begin e = 6'b000110; w = 2'b01; m = 1'b1; end
            4'hB: begin e = 6'b000110; m = 1'b1; end
            4'hE: begin e = 6'b000110; w = 2'b10; end
            4'h6: begin e = 6'b001000; w = 2'b01; end
            4'h7: e = 6'b001000;
            4'hC: e = 6'b001100;
            default: il = 1'b1;
        endcase
        return {ins, npc, e, w, m, il};
    endfunction

    task automatic drive(input logic [15:0] ins, input logic [15:0] npc, input logic [41:0] e);
        @(negedge clock);
        enable_decode = 1'b1;
        instr_dout    = ins;
        npc_in        = npc;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b0; enable_decode = 1'b1; instr_dout = 16'hFFFF; npc_in = 16'hFFFF;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (observed() !== 42'h0) begin
            errors++; $display("FAIL reset_async: got %h want 0", observed());
        end
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (observed() !== 42'h0) begin
            errors++; $display("FAIL reset_dominates: got %h want 0", observed());
        end
        @(negedge clock);
        enable_decode = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (observed() !== 42'h0) begin
            errors++; $display("FAIL reset_hold_after_release: got %h want 0", observed());
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        enable_decode = 1'b1; instr_dout = 16'hFFFF; npc_in = 16'h1234;
        sb_q.push_back(vec(16'hFFFF, 16'h1234, 6'b0, 2'b0, 1'b0, 1'b1));
        @(posedge clock); #1;
        exp_v = sb_q.pop_front();
        checks++;
        if (observed() !== exp_v) begin
            errors++; $display("FAIL first_edge_after_release: got %h want %h", observed(), exp_v);
        end
    endtask

    task automatic test_add();
        drive(16'h1283, 16'h3001, vec(16'h1283, 16'h3001, 6'b000001, 2'b00, 1'b0, 1'b0));
        @(posedge clock); #1;
        exp_v = sb_q.pop_front();
        checks++;
        if (observed() !== exp_v) begin
            errors++; $display("FAIL add_capture: got %h want %h", observed(), exp_v);
        end
    endtask

    task automatic test_hold();
        drive(16'h5262, 16'h4000, vec(16'h5262, 16'h4000, 6'b010000, 2'b00, 1'b0, 1'b0));
        @(posedge clock); #1;
        exp_v = sb_q.pop_front();
        checks++;
        if (observed() !== exp_v) begin
            errors++; $display("FAIL and_imm_capture: got %h want %h", observed(), exp_v);
        end
        @(negedge clock);
        enable_decode = 1'b0; instr_dout = 16'hA000; npc_in = 16'h7777;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            checks++;
            if (observed() !== exp_v) begin
                errors++; $display("FAIL hold_cycle%0d: got %h want %h", i, observed(), exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ins [5];
        logic [5:0]  es  [5];
        logic [1:0]  ws  [5];
        logic        ms  [5];
        ins = '{16'hA405, 16'hB405, 16'h6442, 16'hE40A, 16'hC1C0};
        es  = '{6'b000110, 6'b000110, 6'b001000, 6'b000110, 6'b001100};
        ws  = '{2'b01, 2'b00, 2'b01, 2'b10, 2'b00};
        ms  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(ins[i], 16'h3100 + 16'(i), vec(ins[i], 16'h3100 + 16'(i), es[i], ws[i], ms[i],
                                                 1'b0));
            @(posedge clock); #1;
            exp_v = sb_q.pop_front();
            checks++;
            if (observed() !== exp_v) begin
                errors++; $display("FAIL b2b_%0d: got %h want %h", i, observed(), exp_v);
            end
        end
    endtask

    task automatic test_illegal();
        drive(16'hF025, 16'h5000, vec(16'hF025, 16'h5000, 6'b0, 2'b0, 1'b0, 1'b1));
        @(posedge clock); #1;
        exp_v = sb_q.pop_front();
        checks++;
        if (observed() !== exp_v) begin
            errors++; $display("FAIL illegal_trap: got %h want %h", observed(), exp_v);
        end
        drive(16'h1021, 16'h5001, vec(16'h1021, 16'h5001, 6'b000000, 2'b00, 1'b0, 1'b0));
        @(posedge clock); #1;
        exp_v = sb_q.pop_front();
        checks++;
        if (observed() !== exp_v) begin
            errors++; $display("FAIL illegal_clear: got %h want %h", observed(), exp_v);
        end
    endtask

    task automatic test_opcode_sweep();
        logic [15:0] ins;
        logic [15:0] npc;
        for (int op = 0; op < 16; op++) begin
            for (int b = 0; b < 2; b++) begin
                ins = 16'($urandom);
                ins[15:12] = 4'(op);
                ins[5] = 1'(b);
                npc = 16'($urandom);
                drive(ins, npc, model(ins, npc));
                @(posedge clock); #1;
                exp_v = sb_q.pop_front();
                checks++;
                if (observed() !== exp_v) begin
                    errors++;
                    $display("FAIL sweep_op%h_b%0d: got %h want %h", op, b, observed(), exp_v);
                end
            end
        end
    endtask

    task automatic test_midstream_reset();
        drive(16'h1283, 16'h3001, vec(16'h1283, 16'h3001, 6'b000001, 2'b00, 1'b0, 1'b0));
        @(posedge clock); #1;
        exp_v = sb_q.pop_front();
        checks++;
        if (observed() !== exp_v) begin
            errors++; $display("FAIL mid_pre_capture: got %h want %h", observed(), exp_v);
        end
        @(negedge clock);
        enable_decode = 1'b1; instr_dout = 16'h5262; npc_in = 16'h3002;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (observed() !== 42'h0) begin
            errors++; $display("FAIL mid_async_clear: got %h want 0", observed());
        end
        @(posedge clock); #1;
        checks++;
        if (observed() !== 42'h0) begin
            errors++; $display("FAIL mid_reset_edge: got %h want 0", observed());
        end
        @(negedge clock);
        reset = 1'b0; enable_decode = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (observed() !== 42'h0) begin
            errors++; $display("FAIL mid_no_stale: got %h want 0", observed());
        end
        drive(16'h1021, 16'h3003, vec(16'h1021, 16'h3003, 6'b000000, 2'b00, 1'b0, 1'b0));
        @(posedge clock); #1;
        exp_v = sb_q.pop_front();
        checks++;
        if (observed() !== exp_v) begin
            errors++; $display("FAIL mid_new_capture: got %h want %h", observed(), exp_v);
        end
        @(negedge clock);
        enable_decode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_hold();
        test_back_to_back();
        test_illegal();
        test_opcode_sweep();
        test_midstream_reset();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
